dmem_arbiter: RTL

- Shares the single data-RAM port of the memory block between two requesters: the rv32i processor data port (cpu_*) and a debug/loader port (dbg_*) used to preload or inspect RAM.
- Sits between the processor, the debug master and the memory block's RAM side (`en` / `addr_ram` / `data` / `out_ram`).
- Performs cycle-by-cycle arbitration, returns read data to the requester that issued the read, and bounds debug starvation.

---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/dmem_arbiter_if.sv | 29 ++
 rtl/dmem_arb_core.sv | 112 +++++++++++
 rtl/dmem_arbiter.sv | 90 +++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: owner state encoding,
// default bus widths, arbitration policy codes and a saturating counter helper.
package dmem_pkg;

    localparam int DMEM_AW = 16;
    localparam int DMEM_DW = 32;

    localparam int RR_FIXED = 0;
    localparam int RR_ROUND = 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CPU_OWN = 2'd1;
    localparam logic [1:0] ST_DBG_OWN = 2'd2;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_DBG = 1'b1
    } owner_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-RAM arbiter: request/qualifiers in,
// grant/stall and read return out. master = requester, slave = arbiter.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int AW = DMEM_AW,
    parameter int DW = DMEM_DW
);

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          stall;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, stall, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, stall, rvalid, rdata
    );

endinterface

// File: rtl/dmem_arb_core.sv
// Grant decision, last-owner state register and debug starvation counter.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arb_core
    import dmem_pkg::*;
#(
    parameter int RR_MODE  = RR_FIXED,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cpu_req,
    input  logic        i_dbg_req,
    output logic        o_cpu_gnt,
    output logic        o_dbg_gnt
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0] o_conflict_cnt,
    output logic [15:0] o_dbg_force_cnt
`endif
);

    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    owner_e     r_prev_owner;
    logic [7:0] r_wait;
    logic       w_both;
    logic       w_starved;
    logic       w_last_dbg;
    logic       w_dbg_win;

    assign w_both    = i_cpu_req & i_dbg_req;
    assign w_starved = (r_wait == MAX_W);

    // While IDLE the owner before the idle gap decides who goes next in round-robin.
    assign w_last_dbg = (r_state == ST_DBG_OWN) ||
                        ((r_state == ST_IDLE) && (r_prev_owner == OWNER_DBG));

    always_comb begin
        w_dbg_win = 1'b0;
        if (i_dbg_req) begin
            if (!i_cpu_req) begin
                w_dbg_win = 1'b1;
            end else if (RR_MODE == RR_ROUND) begin
                w_dbg_win = ~w_last_dbg;
            end else begin
                w_dbg_win = w_starved;
            end
        end
    end

    assign o_dbg_gnt = w_dbg_win;
    assign o_cpu_gnt = i_cpu_req & ~w_dbg_win;

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (o_cpu_gnt) begin
            w_state_nxt = ST_CPU_OWN;
        end else if (o_dbg_gnt) begin
            w_state_nxt = ST_DBG_OWN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_prev_owner <= OWNER_CPU;
        end else begin
            r_state <= w_state_nxt;
            if (o_cpu_gnt) begin
                r_prev_owner <= OWNER_CPU;
            end else if (o_dbg_gnt) begin
                r_prev_owner <= OWNER_DBG;
            end
        end
    end

    // Counts consecutive lost cycles of a pending debug request; round-robin never needs it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
        end else if ((RR_MODE != RR_FIXED) || !i_dbg_req || o_dbg_gnt) begin
            r_wait <= '0;
        end else if (!w_starved) begin
            r_wait <= r_wait + 8'd1;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_conflict_cnt;
    logic [15:0] r_force_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
            r_force_cnt    <= '0;
        end else begin
            if (w_both) begin
                r_conflict_cnt <= sat_inc16(r_conflict_cnt);
            end
            if (o_dbg_gnt && i_cpu_req && (RR_MODE == RR_FIXED)) begin
                r_force_cnt <= sat_inc16(r_force_cnt);
            end
        end
    end

    assign o_conflict_cnt  = r_conflict_cnt;
    assign o_dbg_force_cnt = r_force_cnt;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-RAM port between the CPU and the debug/loader master.
// Define DMEM_ARB_STATS_EN to add the conflict_cnt / dbg_force_cnt outputs.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW       = DMEM_AW,
    parameter int DW       = DMEM_DW,
    parameter int RR_MODE  = RR_FIXED,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave cpu,
    dmem_arbiter_if.slave dbg,
    output logic          ram_en,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]   conflict_cnt,
    output logic [15:0]   dbg_force_cnt
`endif
);

    logic          w_cpu_gnt;
    logic          w_dbg_gnt;
    logic          r_cpu_rvalid;
    logic          r_dbg_rvalid;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_dbg_rdata;

    dmem_arb_core #(
        .RR_MODE  (RR_MODE),
        .MAX_WAIT (MAX_WAIT)
    ) u_core (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_cpu_req       (cpu.req),
        .i_dbg_req       (dbg.req),
        .o_cpu_gnt       (w_cpu_gnt),
        .o_dbg_gnt       (w_dbg_gnt)
`ifdef DMEM_ARB_STATS_EN
        ,
        .o_conflict_cnt  (conflict_cnt),
        .o_dbg_force_cnt (dbg_force_cnt)
`endif
    );

    assign cpu.gnt   = w_cpu_gnt;
    assign dbg.gnt   = w_dbg_gnt;
    assign cpu.stall = cpu.req & ~w_cpu_gnt;
    assign dbg.stall = dbg.req & ~w_dbg_gnt;

    // Without a debug grant the RAM sees the CPU bus; ram_en keeps it harmless.
    assign ram_addr  = w_dbg_gnt ? dbg.addr  : cpu.addr;
    assign ram_wdata = w_dbg_gnt ? dbg.wdata : cpu.wdata;
    assign ram_en    = (w_dbg_gnt & dbg.we) | (w_cpu_gnt & cpu.we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= w_cpu_gnt & ~cpu.we;
            r_dbg_rvalid <= w_dbg_gnt & ~dbg.we;
        end
    end

    // RAM data is only valid for one cycle, so each port keeps its own copy afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            if (r_cpu_rvalid) begin
                r_cpu_rdata <= ram_rdata;
            end
            if (r_dbg_rvalid) begin
                r_dbg_rdata <= ram_rdata;
            end
        end
    end

    assign cpu.rvalid = r_cpu_rvalid;
    assign dbg.rvalid = r_dbg_rvalid;
    assign cpu.rdata  = r_cpu_rvalid ? ram_rdata : r_cpu_rdata;
    assign dbg.rdata  = r_dbg_rvalid ? ram_rdata : r_dbg_rdata;

endmodule
